uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; counterpart of the core's UART transmitter (which is fed from r31).
//  - Samples the asynchronous serial input pin, rebuilds bytes LSB-first and buffers them in a small FIFO.
//  - The register file/CPU pops bytes with a one-cycle rd_en strobe.
//  - Framing errors and overruns are reported as sticky flags.
// PARAMETERS
//  CLKS_PER_BIT  434  CLK_DC cycles per bit (50 MHz / 115200); must be >= 4
//  FIFO_DEPTH    4    receive buffer entries; power of two, >= 2
// PORTS
//  CLK_DC     in   1   receiver clock; every register in the block is on its rising edge
//  RST        in   1   asynchronous, active-low reset
//  uartRxPin  in   1   serial input; idle high; asynchronous to CLK_DC
//  rd_en      in   1   pop head byte this cycle; ignored when rx_valid=0
//  err_clr    in   1   clears frame_err and overrun
//  rx_data    out  8   FIFO head byte (show-ahead); 0 when empty
//  rx_valid   out  1   FIFO not empty
//  rx_count   out  $clog2(FIFO_DEPTH+1)  bytes currently buffered
//  frame_err  out  1   sticky: a stop bit was sampled low
//  overrun    out  1   sticky: a good byte arrived while the FIFO was full and was dropped
// BEHAVIOUR
//  - Reset: every output is 0, FSM=IDLE, FIFO empty, bit counter 0.
//    Both 2-FF synchronizer stages reset to 1 (line idle). Async assert, sync deassert via the flop edge.
//  - rx_s is the 2-FF synchronized uartRxPin. The FSM uses only rx_s.
//  - FSM states:
//    IDLE : when rx_s==0, clear cnt and go to START.
//    START: at cnt==CLKS_PER_BIT/2-1 (mid start bit), re-sample rx_s.
//           0 -> go to DATA, cnt=0, bitidx=0.
//           1 -> glitch; return to IDLE with no other effect.
//    DATA : at cnt==CLKS_PER_BIT-1, shift rx_s into sh[bitidx] (LSB first) and set cnt=0.
//           After bitidx 7 is sampled, go to STOP.
//    STOP : at cnt==CLKS_PER_BIT-1, sample rx_s.
//           1 -> push sh into the FIFO and go to IDLE.
//           0 -> set frame_err, discard the byte, go to BREAK.
//    BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one frame_err.
//  - Latency: rx_valid rises on the cycle after the stop-bit sample edge when the FIFO was empty.
//    Bits are sampled at nominal mid-bit ±1 cycle of synchronizer delay.
//  - FIFO: read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
//    rx_count = wr_ptr - rd_ptr.
//  - Push while full with no pop: drop the byte, set overrun; the contents are unchanged.
//  - Push and pop in the same cycle, including when full: both take effect, count is unchanged, no overrun.
//  - rd_en while empty: no effect; pointers do not move.
//  - Simultaneous err_clr and a new error event: the set wins and the flag stays 1.
//  - A reset mid-byte abandons the byte silently; the FSM then waits in IDLE for the next falling edge.
// STRUCTURE
//  - uart_pkg holds:
//    - typedef enum logic [2:0] {IDLE,START,DATA,STOP,BREAK} uart_rx_state_t
//    - localparam UART_DEFAULT_CLKS_PER_BIT=434
//    - localparam UART_DATA_BITS=8
//  - One sub-module, uart_rx_fifo (DEPTH, WIDTH=8; push/pop/full/empty/count).
//  - Synchronizer, bit counter and FSM live in uart_rx.
//  - cnt is $clog2(CLKS_PER_BIT) bits wide; bitidx is 3 bits.
// TESTING (CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Drive 0xA5 8N1 at 16 clk/bit -> rx_valid=1 and rx_data=0xA5; after one rd_en pulse, rx_valid=0 and rx_count=0.
//  2. Pulse the pin low for 4 clocks, then hold it high -> FSM returns to IDLE; rx_valid, frame_err and overrun stay 0.
//  3. Send 0x3C with the stop bit low for 3 bit times, then high -> frame_err=1 (once), FIFO empty.
//     A following 0x5A is received correctly; err_clr then drops frame_err to 0.
//  4. Send 0x01..0x05 back-to-back with no reads -> rx_count=4 and overrun=1.
//     Reads return 0x01,0x02,0x03,0x04, then rx_valid=0.
//  5. With the FIFO full, assert rd_en on the push cycle of byte 0x77 -> overrun stays 0, rx_count stays 4.
//     0x77 is the last byte read out.
//  6. Assert RST low mid-DATA of byte 0xFF -> all outputs 0 immediately.
//     After release, 0x81 is received correctly and no stale bits appear.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

   localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;
   localparam int unsigned UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; wrap-bit pointers, simultaneous push/pop allowed even when full.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      w_diff;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_diff    = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = CW'(w_diff);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot the push needs.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, receive FIFO and sticky errors.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                             CLK_DC,
   input  logic                             RST,
   input  logic                             uartRxPin,
   input  logic                             rd_en,
   input  logic                             err_clr,
   output logic [7:0]                       rx_data,
   output logic                             rx_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
   output logic                             frame_err,
   output logic                             overrun
);

   localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
   localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CLKS_PER_BIT - 1);

   logic                      r_sync1;
   logic                      r_rx_s;
   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_nxt;
   logic [CNTW-1:0]           r_cnt;
   logic [CNTW-1:0]           w_cnt_nxt;
   logic [2:0]                r_bitidx;
   logic [2:0]                w_bitidx_nxt;
   logic [UART_DATA_BITS-1:0] r_sh;
   logic [UART_DATA_BITS-1:0] w_sh_nxt;
   logic                      w_push;
   logic                      w_ferr_set;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
   logic                      r_frame_err;
   logic                      r_overrun;

   // Synchronizer resets to idle-high so reset release never looks like a start bit.
   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= uartRxPin;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bitidx <= '0;
         r_sh     <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_bitidx <= w_bitidx_nxt;
         r_sh     <= w_sh_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt + 1'b1;
      w_bitidx_nxt = r_bitidx;
      w_sh_nxt     = r_sh;
      w_push       = 1'b0;
      w_ferr_set   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!r_rx_s) w_state_nxt = START;
         end
         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt    = '0;
               w_bitidx_nxt = '0;
               w_state_nxt  = r_rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt          = '0;
               w_sh_nxt[r_bitidx] = r_rx_s;
               w_bitidx_nxt       = r_bitidx + 1'b1;
               if (r_bitidx == 3'd7) w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_push      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_set  = 1'b1;
                  w_state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            w_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Setting wins over a simultaneous clear.
   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_ferr_set | (r_frame_err & ~err_clr);
         r_overrun   <= (w_push & w_fifo_full & ~rd_en) | (r_overrun & ~err_clr);
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .i_clk   (CLK_DC),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_data  (r_sh),
      .i_pop   (rd_en),
      .o_data  (rx_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (rx_count)
   );

   assign rx_valid  = ~w_fifo_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pin = 1'b1;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] rx_count;
   logic       frame_err;
   logic       overrun;

   int errors = 0;
   int checks = 0;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .CLK_DC    (clk),
      .RST       (rst),
      .uartRxPin (pin),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_count  (rx_count),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic v, input int n);
      pin = v;
      repeat (n * CPB) @(negedge clk);
   endtask

   // stop_low: number of bit times the stop bit is held low before going high.
   task automatic send_byte(input logic [7:0] b, input int stop_low);
      bit_time(1'b0, 1);
      for (int i = 0; i < 8; i++) bit_time(b[i], 1);
      if (stop_low > 0) bit_time(1'b0, stop_low);
      bit_time(1'b1, 1);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_count", rx_count, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_state", dut.r_state, IDLE);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // rd_en on an empty FIFO must not move pointers
      pop();
      chk("empty_pop_count", rx_count, 0);
      chk("empty_pop_valid", rx_valid, 0);

      // 1: single byte
      send_byte(8'hA5, 0);
      @(negedge clk);
      chk("t1_valid", rx_valid, 1);
      chk("t1_data", rx_data, 8'hA5);
      chk("t1_count", rx_count, 1);
      pop();
      chk("t1_valid_after", rx_valid, 0);
      chk("t1_count_after", rx_count, 0);
      chk("t1_data_after", rx_data, 0);

      // 2: short glitch
      bit_time(1'b1, 1);
      pin = 1'b0;
      repeat (4) @(negedge clk);
      pin = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("t2_state", dut.r_state, IDLE);
      chk("t2_valid", rx_valid, 0);
      chk("t2_ferr", frame_err, 0);
      chk("t2_ovr", overrun, 0);

      // 3: framing error then recovery
      send_byte(8'h3C, 3);
      @(negedge clk);
      chk("t3_ferr", frame_err, 1);
      chk("t3_valid", rx_valid, 0);
      chk("t3_state", dut.r_state, IDLE);
      send_byte(8'h5A, 0);
      @(negedge clk);
      chk("t3_good_valid", rx_valid, 1);
      chk("t3_good_data", rx_data, 8'h5A);
      chk("t3_ferr_sticky", frame_err, 1);
      pulse_clr();
      chk("t3_ferr_clr", frame_err, 0);
      pop();
      chk("t3_empty", rx_valid, 0);

      // 4: overrun
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      @(negedge clk);
      chk("t4_count", rx_count, 4);
      chk("t4_ovr", overrun, 1);
      chk("t4_ferr", frame_err, 0);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_read", rx_data, i);
         pop();
      end
      chk("t4_valid_end", rx_valid, 0);
      pulse_clr();
      chk("t4_ovr_clr", overrun, 0);

      // 5: push and pop on the same cycle while full
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 0);
      chk("t5_full", rx_count, 4);
      fork
         send_byte(8'h77, 0);
         begin
            int n;
            n = 0;
            while (!dut.w_push && n < 400) begin
               @(negedge clk);
               n++;
            end
            chk("t5_push_seen", n < 400, 1);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
         end
      join
      @(negedge clk);
      chk("t5_ovr", overrun, 0);
      chk("t5_count", rx_count, 4);
      for (int i = 0; i < 3; i++) begin
         chk("t5_read", rx_data, 8'h12 + i);
         pop();
      end
      chk("t5_last", rx_data, 8'h77);
      pop();
      chk("t5_empty", rx_valid, 0);

      // 6: reset mid-byte
      send_byte(8'h42, 0);
      chk("t6_pre_count", rx_count, 1);
      bit_time(1'b0, 1);
      bit_time(1'b1, 3);
      chk("t6_in_data", dut.r_state, DATA);
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", rx_valid, 0);
      chk("t6_rst_count", rx_count, 0);
      chk("t6_rst_data", rx_data, 0);
      chk("t6_rst_ferr", frame_err, 0);
      chk("t6_rst_ovr", overrun, 0);
      chk("t6_rst_state", dut.r_state, IDLE);
      @(negedge clk);
      rst = 1'b1;
      bit_time(1'b1, 6);
      chk("t6_idle_after", dut.r_state, IDLE);
      send_byte(8'h81, 0);
      @(negedge clk);
      chk("t6_data", rx_data, 8'h81);
      chk("t6_count", rx_count, 1);
      chk("t6_ferr", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
